// File: rtl/widthcr_calc.sv
// Cr-cluster width W_Cr(Y) of the luma-dependent skin-tone model, three-stage pipeline.
// Optional macro WIDTHCR_MID_WIDTH_EN makes the mid-luma plateau output W_CR instead of 0.
module widthcr_calc #(
  parameter int WIDTHCR_WIDTH = 16,
  parameter int FRAC_BITS     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               y_in,
  output logic                     out_valid,
  output logic [WIDTHCR_WIDTH-1:0] widthcr_out
);

  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] K_L   = 8'd125;
  localparam logic [7:0] K_H   = 8'd188;
  localparam int SLOPE_FRAC    = 16;

  // W_CR=38.76 is carried in hundredths so every constant stays integer.
  localparam logic [63:0] ONE_Q   = 64'd1 << FRAC_BITS;
  localparam logic [63:0] WCR_Q64 = (64'd3876 * ONE_Q + 64'd50) / 64'd100;
  localparam logic [63:0] WL_Q64  = 64'd20 * ONE_Q;
  localparam logic [63:0] WH_Q64  = 64'd10 * ONE_Q;
  localparam logic [63:0] SL_Q64  = (64'd1876 * (ONE_Q << SLOPE_FRAC) + 64'd5450) / 64'd10900;
  localparam logic [63:0] SH_Q64  = (64'd2876 * (ONE_Q << SLOPE_FRAC) + 64'd2350) / 64'd4700;

  localparam logic [WIDTHCR_WIDTH-1:0] WCR_Q = WIDTHCR_WIDTH'(WCR_Q64);
  localparam logic [WIDTHCR_WIDTH-1:0] WL_Q  = WIDTHCR_WIDTH'(WL_Q64);
  localparam logic [WIDTHCR_WIDTH-1:0] WH_Q  = WIDTHCR_WIDTH'(WH_Q64);
  localparam logic [47:0]              S_L   = 48'(SL_Q64);
  localparam logic [47:0]              S_H   = 48'(SH_Q64);

  typedef enum logic [1:0] {
    RNG_LOW  = 2'd0,
    RNG_HIGH = 2'd1,
    RNG_MID  = 2'd2
  } rng_t;

  logic [7:0]               w_yc;
  logic [7:0]               w_diff;
  rng_t                     w_rng;
  logic [47:0]              w_slope;
  logic [WIDTHCR_WIDTH-1:0] w_round;
  logic [WIDTHCR_WIDTH-1:0] w_result;

  logic                     r_v1;
  logic [7:0]               r_diff1;
  rng_t                     r_rng1;
  logic                     r_v2;
  logic [47:0]              r_prod2;
  rng_t                     r_rng2;
  logic                     r_out_valid;
  logic [WIDTHCR_WIDTH-1:0] r_widthcr;

  // Range selection looks at the unclamped sample; the distance uses the clamped one.
  always_comb begin
    w_yc   = y_in;
    w_diff = 8'd0;
    w_rng  = RNG_MID;
    if (y_in < Y_MIN)
      w_yc = Y_MIN;
    else if (y_in > Y_MAX)
      w_yc = Y_MAX;
    if (y_in <= K_L) begin
      w_rng  = RNG_LOW;
      w_diff = w_yc - Y_MIN;
    end else if (y_in >= K_H) begin
      w_rng  = RNG_HIGH;
      w_diff = Y_MAX - w_yc;
    end
  end

  assign w_slope = (r_rng1 == RNG_HIGH) ? S_H : S_L;
  assign w_round = WIDTHCR_WIDTH'((r_prod2 + 48'd32768) >> SLOPE_FRAC);

  always_comb begin
    w_result = '0;
    case (r_rng2)
      RNG_LOW:  w_result = WL_Q + w_round;
      RNG_HIGH: w_result = WH_Q + w_round;
`ifdef WIDTHCR_MID_WIDTH_EN
      RNG_MID:  w_result = WCR_Q;
`else
      RNG_MID:  w_result = '0;
`endif
      default:  w_result = '0;
    endcase
  end

  // Valid bits always advance; data registers only load behind a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_diff1     <= 8'd0;
      r_rng1      <= RNG_MID;
      r_v2        <= 1'b0;
      r_prod2     <= 48'd0;
      r_rng2      <= RNG_MID;
      r_out_valid <= 1'b0;
      r_widthcr   <= '0;
    end else begin
      r_v1        <= in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
      if (in_valid) begin
        r_diff1 <= w_diff;
        r_rng1  <= w_rng;
      end
      if (r_v1) begin
        r_prod2 <= 48'(r_diff1) * w_slope;
        r_rng2  <= r_rng1;
      end
      if (r_v2)
        r_widthcr <= w_result;
    end
  end

  assign out_valid   = r_out_valid;
  assign widthcr_out = r_widthcr;

endmodule

// File: tb/tb_widthcr_calc.sv
// Scoreboard bench for widthcr_calc: directed endpoints, reset, gaps and a full luma sweep.
// Expected values are hand-computed constants or an independent real-valued model.
module tb_widthcr_calc;

  typedef struct {
    int y;
    int exp;
    int tol;
  } sbEntry_t;

`ifdef WIDTHCR_MID_WIDTH_EN
  localparam int MID_EXP = 39690;
`else
  localparam int MID_EXP = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  y_in;
  logic        out_valid;
  logic [15:0] widthcr_out;

  sbEntry_t sb[$];
  int       asserts;
  int       fails;
  int       lastExp;
  int       lastTol;
  logic [2:0] vp;

  widthcr_calc #(.WIDTHCR_WIDTH(16), .FRAC_BITS(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .y_in(y_in),
    .out_valid(out_valid),
    .widthcr_out(widthcr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real-valued reference of the width curve, rounded to Q6.10.
  function automatic int modelQ(input int y);
    real yc;
    real w;
    yc = (y < 16) ? 16.0 : ((y > 235) ? 235.0 : real'(y));
    if (y <= 125)
      w = 20.0 + (yc - 16.0) * 18.76 / 109.0;
    else if (y >= 188)
      w = 10.0 + (235.0 - yc) * 28.76 / 47.0;
    else
      return MID_EXP;
    return int'($floor(w * 1024.0 + 0.5));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int d;
    asserts++;
    d = actual - expected;
    if (d < 0) d = -d;
    if (d > tol) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
    end
  endtask

  task automatic applyStimulus(input int y, input int expected, input int tol);
    sbEntry_t e;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    y_in     = 8'(y);
    e.y = y;
    e.exp = expected;
    e.tol = tol;
    sb.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    y_in     = 8'd70;
    sb.delete();
    lastExp  = 0;
    lastTol  = 0;
    repeat (cycles) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Expected out_valid: in_valid delayed by three register stages.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vp <= 3'b000;
    else
      vp <= {vp[1:0], in_valid};
  end

  // Monitor: sample away from the active edge and pop the scoreboard on each valid output.
  always @(negedge clk) begin
    sbEntry_t e;
    if (!rst_n) begin
      checkOutput("reset out_valid", int'(out_valid), 0, 0);
      checkOutput("reset widthcr_out", int'(widthcr_out), 0, 0);
    end else begin
      checkOutput("out_valid timing", int'(out_valid), int'(vp[2]), 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          asserts++;
          fails++;
          $display("[TB] FAIL unexpected output: got %0d, expected no output", widthcr_out);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("y=%0d", e.y), int'(widthcr_out), e.exp, e.tol);
          lastExp = e.exp;
          lastTol = e.tol;
        end
      end else begin
        checkOutput("hold during gap", int'(widthcr_out), lastExp, lastTol);
      end
    end
  end

  initial begin
    int waited;
    asserts  = 0;
    fails    = 0;
    lastExp  = 0;
    lastTol  = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    y_in     = 8'd70;
    repeat (4) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idleCycles(3);
    $display("[TB] directed endpoints");

    applyStimulus(16, 20480, 0);
    applyStimulus(125, 39690, 0);
    applyStimulus(70, 29997, 1);
    applyStimulus(0, 20480, 0);
    applyStimulus(188, 39690, 0);
    applyStimulus(235, 10240, 0);
    applyStimulus(200, 32171, 1);
    applyStimulus(255, 10240, 0);
    applyStimulus(126, MID_EXP, 0);
    applyStimulus(150, MID_EXP, 0);
    applyStimulus(187, MID_EXP, 0);
    idleCycles(4);

    $display("[TB] gapped valid");
    applyStimulus(16, 20480, 0);
    idleCycles(1);
    applyStimulus(235, 10240, 0);
    idleCycles(1);
    applyStimulus(125, 39690, 0);
    idleCycles(5);

    $display("[TB] reset mid-stream");
    applyStimulus(100, modelQ(100), 1);
    applyStimulus(200, 32171, 1);
    applyReset(2);
    idleCycles(3);
    applyStimulus(188, 39690, 0);
    idleCycles(4);

    $display("[TB] full sweep");
    for (int y = 0; y < 256; y++)
      applyStimulus(y, modelQ(y), 1);
    idleCycles(2);

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending outputs, expected 0", sb.size());
    end
    idleCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/widthcr_calc.md
Name: widthcr_calc

Overview:
- Computes the Cr-cluster width W_Cr(Y) of the luma-dependent skin-tone model from an 8-bit luma sample.
- Sits in the skin-tone accelerator datapath beside the matching Cb-width and centre blocks; its result feeds the elliptical skin classifier.
- Pipelined, one sample per clock, unsigned fixed-point result.

Parameters:
- WIDTHCR_WIDTH, 16, output width in bits; unsigned fixed point.
- FRAC_BITS, 10, fractional bits of the output, giving Q6.10 at default.
- Model constants are fixed localparams: W_CR=38.76, WL_CR=20, WH_CR=10, K_L=125, K_H=188, Y_MIN=16, Y_MAX=235.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  y_in is valid this cycle.
- y_in  in  8  luma sample, unsigned 0..255.
- out_valid  out  1  widthcr_out is valid this cycle.
- widthcr_out  out  WIDTHCR_WIDTH  W_Cr(Y) in unsigned Q(WIDTHCR_WIDTH-FRAC_BITS).FRAC_BITS.

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0, out_valid=0, widthcr_out=0, and all pipeline valid bits are 0.
- Latency: a sample accepted with in_valid=1 on edge N appears with out_valid=1 after edge N+2. Throughput is 1 per cycle.
- No backpressure.
- Pipeline data registers load only when the corresponding valid bit is 1. widthcr_out holds its last value while out_valid=0.
- Clamp: Yc = max(Y_MIN, min(Y_MAX, y_in)).
- Low range, y_in<=K_L: W = WL_CR + (Yc-Y_MIN)*(W_CR-WL_CR)/(K_L-Y_MIN).
- High range, y_in>=K_H: W = WH_CR + (Y_MAX-Yc)*(W_CR-WH_CR)/(Y_MAX-K_H).
- Mid range, K_L<y_in<K_H: W = 0.
- Range selection uses the unclamped y_in.
- Output: widthcr_out = round-to-nearest(W*2^FRAC_BITS). Maximum error is 1 LSB versus the real-valued model.
- Implementation: slopes are precomputed constant multipliers with at least 16 fractional bits. No divider.
- Arithmetic never overflows the output at default width; maximum is 39690.
- A reset asserted mid-stream discards all in-flight samples. The first output after reset release comes 2 cycles after the next in_valid.
- Boundary values:
  - Yc=Y_MIN gives exactly WL_CR.
  - y_in=K_L and y_in=K_H both give round(W_CR*2^FRAC_BITS).
  - Yc=Y_MAX gives exactly WH_CR.

Optional Feature:
- Macro: WIDTHCR_MID_WIDTH_EN.
- When defined, the mid range (125<y_in<188) outputs round(W_CR*2^FRAC_BITS)=39690. The width curve is then continuous across the plateau.
- When undefined, mid range outputs 0, which is the default build.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset: assert rst_n=0 with in_valid=1 -> out_valid=0 and widthcr_out=0 throughout. Release rst_n; first out_valid comes 2 cycles after the next in_valid.
- Low-range endpoints: y_in=16 -> 20480. y_in=125 -> 39690. y_in=70 -> 29997±1. y_in=0 -> 20480 (clamped).
- High-range endpoints: y_in=188 -> 39690. y_in=235 -> 10240. y_in=200 -> 32171±1. y_in=255 -> 10240 (clamped).
- Mid range: y_in=126, 150, 187 -> 0. With WIDTHCR_MID_WIDTH_EN defined, the same inputs give 39690.
- Full sweep: y_in=0..255 back-to-back with in_valid=1 -> 256 consecutive out_valid pulses, each output within 1 LSB of the real model and in input order.
- Gapped valid: in_valid toggling 1,0,1 -> out_valid mirrors the pattern 2 cycles later, and widthcr_out holds its value during gaps.
